// File: rtl/mbe_final_adder.sv
`default_nettype none
// ============================================================================
// Module   : mbe_final_adder
// Brief    : Multi-cycle segmented carry-propagate adder that resolves the
//            Dadda tree {sum, carry} pair into the final product, SEG bits
//            per clock, behind valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module mbe_final_adder #(
   parameter int WIDTH = 22,
   parameter int SEG   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum_in,
   input  logic [WIDTH-1:0] carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] product,
   output logic             cout
);

   localparam int NSEG = (WIDTH + SEG - 1) / SEG;
   localparam int LAST = WIDTH - (NSEG - 1) * SEG;
   localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q,   state_d;
   logic [IDXW-1:0]   idx_q,     idx_d;
   logic              cy_q,      cy_d;
   logic [WIDTH-1:0]  opa_q,     opa_d;
   logic [WIDTH-1:0]  opb_q,     opb_d;
   logic [WIDTH-1:0]  product_q, product_d;
   logic              cout_q,    cout_d;

   logic [SEG-1:0]    s_slice;
   logic [SEG-1:0]    c_slice;
   logic [SEG:0]      seg_sum;
   logic              seg_last;
   logic              seg_carry;

   // Operand slice selection uses only constant bit indices; the final
   // slice's unused high bits stay zero, so its carry lands at bit LAST.
   always_comb begin
      s_slice = '0;
      c_slice = '0;
      for (int b = 0; b < WIDTH; b++) begin
         if (idx_q == IDXW'(b / SEG)) begin
            s_slice[b % SEG] = opa_q[b];
            c_slice[b % SEG] = opb_q[b];
         end
      end
      seg_sum   = {1'b0, s_slice} + {1'b0, c_slice} + {{SEG{1'b0}}, cy_q};
      seg_last  = (idx_q == IDXW'(NSEG - 1));
      seg_carry = seg_last ? seg_sum[LAST] : seg_sum[SEG];
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cy_d      = cy_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      product_d = product_q;
      cout_d    = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               opa_d   = sum_in;
               opb_d   = carry_in;
               idx_d   = '0;
               cy_d    = 1'b0;
               state_d = ADD;
            end
         end
         ADD: begin
            for (int b = 0; b < WIDTH; b++) begin
               if (idx_q == IDXW'(b / SEG)) begin
                  product_d[b] = seg_sum[b % SEG];
               end
            end
            cy_d = seg_carry;
            if (seg_last) begin
               cout_d  = seg_carry;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cy_q      <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         product_q <= '0;
         cout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cy_q      <= cy_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         product_q <= product_d;
         cout_q    <= cout_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign product   = product_q;
   assign cout      = cout_q;

endmodule
`default_nettype wire
